// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle controller and memory.
// The controller is the master: it raises mem_req and memory answers with mem_ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Each instruction is sequenced over one shared memory port; the strobes are decoded from state, Op and Funct.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE | classify Op/Funct; illegal encodings retire as a nop
// EXEC   | ALU op, address calculation, or branch/jump resolution
// MEM    | data access at ALUOut; sw retires here
// WB     | ALU / lui result written to the register file
// MEMWB  | load data written to rt
module multicycle_ctrl #(
    parameter int ST_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      Op,
    input  logic [5:0]      Funct,
    input  logic            zero,
    multicycle_ctrl_if.master mem,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic [1:0]      PCControl,
    output logic            ALUAsrc,
    output logic [1:0]      ALUBsrc,
    output logic [2:0]      ALUControl,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemtoReg,
    output logic            RegWrite,
    output logic            instr_done,
    output logic [ST_W-1:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MEMWB  = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    state_t state_q;

    logic is_r, is_addu, is_subu, is_sll, is_jr;
    logic is_ori, is_sltiu, is_lw, is_sw, is_beq, is_lui, is_jal;
    logic is_alu, legal;

    always_comb begin
        is_r     = (Op == OP_RTYPE);
        is_addu  = is_r && (Funct == FN_ADDU);
        is_subu  = is_r && (Funct == FN_SUBU);
        is_sll   = is_r && (Funct == FN_SLL);
        is_jr    = is_r && (Funct == FN_JR);
        is_ori   = (Op == OP_ORI);
        is_sltiu = (Op == OP_SLTIU);
        is_lw    = (Op == OP_LW);
        is_sw    = (Op == OP_SW);
        is_beq   = (Op == OP_BEQ);
        is_lui   = (Op == OP_LUI);
        is_jal   = (Op == OP_JAL);
        is_alu   = is_addu || is_subu || is_sll || is_ori || is_sltiu;
        legal    = is_alu || is_jr || is_lw || is_sw || is_beq || is_lui || is_jal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem.mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (!legal)      state_q <= S_FETCH;
                    else if (is_lui) state_q <= S_WB;
                    else             state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_lw || is_sw) state_q <= S_MEM;
                    else if (is_alu)    state_q <= S_WB;
                    else                state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (mem.mem_ready) state_q <= is_lw ? S_MEMWB : S_FETCH;
                end
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs are gated by reset so an in-flight access or write is abandoned in the same cycle.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_iord = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCControl    = 2'd0;
        ALUAsrc      = 1'b0;
        ALUBsrc      = 2'd0;
        ALUControl   = 3'd0;
        RegDst       = 2'd0;
        MemtoReg     = 2'd0;
        RegWrite     = 1'b0;
        instr_done   = 1'b0;
        state        = '0;
        if (!reset) begin
            state = ST_W'(state_q);
            case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    IRWrite     = mem.mem_ready;
                    PCWrite     = mem.mem_ready;
                end
                S_DECODE: instr_done = !legal;
                S_EXEC: begin
                    if (is_addu) ALUControl = 3'd2;
                    if (is_subu) ALUControl = 3'd3;
                    if (is_sll) begin
                        ALUControl = 3'd4;
                        ALUAsrc    = 1'b1;
                    end
                    if (is_ori) begin
                        ALUControl = 3'd1;
                        ALUBsrc    = 2'd2;
                    end
                    if (is_sltiu) begin
                        ALUControl = 3'd6;
                        ALUBsrc    = 2'd1;
                    end
                    if (is_lw || is_sw) begin
                        ALUControl = 3'd2;
                        ALUBsrc    = 2'd1;
                    end
                    if (is_beq) begin
                        ALUControl = 3'd3;
                        PCWrite    = zero;
                        PCControl  = 2'd1;
                        instr_done = 1'b1;
                    end
                    if (is_jr) begin
                        PCWrite    = 1'b1;
                        PCControl  = 2'd2;
                        instr_done = 1'b1;
                    end
                    if (is_jal) begin
                        RegWrite   = 1'b1;
                        RegDst     = 2'd2;
                        MemtoReg   = 2'd3;
                        PCWrite    = 1'b1;
                        PCControl  = 2'd3;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_iord = 1'b1;
                    mem.mem_we   = is_sw;
                    instr_done   = is_sw && mem.mem_ready;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    RegDst     = is_r ? 2'd1 : 2'd0;
                    MemtoReg   = is_lui ? 2'd2 : 2'd0;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'd1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction streams
// compared cycle by cycle against an instruction-level expected trace.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       zero = 1'b0;
    logic       IRWrite, PCWrite, ALUAsrc, RegWrite, instr_done;
    logic [1:0] PCControl, ALUBsrc, RegDst, MemtoReg;
    logic [2:0] ALUControl;
    logic [2:0] state;

    multicycle_ctrl_if mem_bus ();

    multicycle_ctrl #(.ST_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .zero       (zero),
        .mem        (mem_bus),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCControl  (PCControl),
        .ALUAsrc    (ALUAsrc),
        .ALUBsrc    (ALUBsrc),
        .ALUControl (ALUControl),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcc;
        logic       asrc;
        logic [1:0] bsrc;
        logic [2:0] aluc;
        logic [1:0] rdst, m2r;
        logic       rw, done;
    } outs_t;

    typedef enum {K_ADDU, K_SUBU, K_SLL, K_JR, K_ORI, K_SLTIU, K_LW, K_SW,
                  K_BEQ, K_LUI, K_JAL, K_ILL} kind_t;

    outs_t exp_q[$];
    bit    rdy_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.st   = state;
        o.req  = mem_bus.mem_req;
        o.we   = mem_bus.mem_we;
        o.iord = mem_bus.mem_iord;
        o.irw  = IRWrite;
        o.pcw  = PCWrite;
        o.pcc  = PCControl;
        o.asrc = ALUAsrc;
        o.bsrc = ALUBsrc;
        o.aluc = ALUControl;
        o.rdst = RegDst;
        o.m2r  = MemtoReg;
        o.rw   = RegWrite;
        o.done = instr_done;
        return o;
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: case (fn)
                6'b100001: return K_ADDU;
                6'b100011: return K_SUBU;
                6'b000000: return K_SLL;
                6'b001000: return K_JR;
                default:   return K_ILL;
            endcase
            6'b001101: return K_ORI;
            6'b001011: return K_SLTIU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001111: return K_LUI;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    task automatic push(input outs_t e, input bit rdy);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
    endtask

    // Expected per-cycle trace of one instruction, with wf/wm memory wait cycles in fetch/data access.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm);
        kind_t k = classify(op, fn);
        outs_t e;
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i < wf; i++) begin
            e = blank(3'd0); e.req = 1'b1; push(e, 1'b0);
        end
        e = blank(3'd0); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; push(e, 1'b1);
        e = blank(3'd1); e.done = (k == K_ILL); push(e, 1'($urandom_range(0, 1)));
        if (k == K_ILL) return;
        if (k == K_LUI) begin
            e = blank(3'd4); e.rw = 1'b1; e.done = 1'b1; e.m2r = 2'd2;
            push(e, 1'($urandom_range(0, 1)));
            return;
        end
        e = blank(3'd2);
        case (k)
            K_ADDU:  e.aluc = 3'd2;
            K_SUBU:  e.aluc = 3'd3;
            K_SLL:   begin e.aluc = 3'd4; e.asrc = 1'b1; end
            K_ORI:   begin e.aluc = 3'd1; e.bsrc = 2'd2; end
            K_SLTIU: begin e.aluc = 3'd6; e.bsrc = 2'd1; end
            K_LW, K_SW: begin e.aluc = 3'd2; e.bsrc = 2'd1; end
            K_BEQ:   begin e.aluc = 3'd3; e.pcw = z; e.pcc = 2'd1; e.done = 1'b1; end
            K_JR:    begin e.pcw = 1'b1; e.pcc = 2'd2; e.done = 1'b1; end
            K_JAL:   begin e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd3; e.pcw = 1'b1;
                           e.pcc = 2'd3; e.done = 1'b1; end
            default: ;
        endcase
        push(e, 1'($urandom_range(0, 1)));
        if (k == K_BEQ || k == K_JR || k == K_JAL) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < wm; i++) begin
                e = blank(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = (k == K_SW);
                push(e, 1'b0);
            end
            e = blank(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = (k == K_SW);
            e.done = (k == K_SW);
            push(e, 1'b1);
            if (k == K_SW) return;
            e = blank(3'd5); e.rw = 1'b1; e.m2r = 2'd1; e.done = 1'b1;
            push(e, 1'($urandom_range(0, 1)));
            return;
        end
        e = blank(3'd4); e.rw = 1'b1; e.done = 1'b1; e.rdst = (op == 6'd0) ? 2'd1 : 2'd0;
        push(e, 1'($urandom_range(0, 1)));
    endtask

    task automatic play(input string name, input int n, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, output int dn);
        outs_t o;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            if (i == 0) begin Op = op; Funct = fn; zero = z; end
            mem_bus.mem_ready = rdy_q[i];
            @(negedge clk);
            o = sample();
            chk($sformatf("%s_c%0d", name, i), 32'(o), 32'(exp_q[i]));
            dn += int'(o.done);
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int wf, input int wm);
        int dn;
        build(op, fn, z, wf, wm);
        play(name, exp_q.size(), op, fn, z, dn);
        chk({name, "_retire_cnt"}, 32'(dn), 32'd1);
    endtask

    logic [5:0] op_tab [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0b, 6'h23,
                                6'h2b, 6'h04, 6'h0f, 6'h03, 6'h3f, 6'h00, 6'h02};
    logic [5:0] fn_tab [14] = '{6'h21, 6'h23, 6'h00, 6'h08, 6'h15, 6'h3a, 6'h00,
                                6'h11, 6'h00, 6'h07, 6'h2c, 6'h00, 6'h20, 6'h00};

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        mem_bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("reset_hold_%0d", i), 32'(sample()), 32'd0);
        end

        run_instr("addu", 6'h00, 6'h21, 1'b0, 0, 0);
        run_instr("lw_wait", 6'h23, 6'h00, 1'b0, 2, 2);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, 0, 0);
        run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
        run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0);
        run_instr("illegal", 6'h3f, 6'h00, 1'b0, 0, 0);
        run_instr("lui", 6'h0f, 6'h00, 1'b0, 1, 0);

        // sw abandoned by reset while its data access is still waiting on memory
        build(6'h2b, 6'h00, 1'b0, 0, 3);
        play("sw_abort", 4, 6'h2b, 6'h00, 1'b0, dn);
        @(posedge clk); #1;
        reset = 1'b1;
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_outs_same_cycle", 32'(sample()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_outs_held", 32'(sample()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        begin
            outs_t e = blank(3'd0);
            e.req = 1'b1;
            chk("abort_back_to_fetch", 32'(sample()), 32'(e));
        end

        for (int n = 0; n < 200; n++) begin
            int idx = $urandom_range(0, 13);
            run_instr($sformatf("rnd%0d", n), op_tab[idx], fn_tab[idx],
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
